dataflow_ready_sync: RTL and testbench
======================================

Name: dataflow_ready_sync

Overview:
- Top-level start/ready synchroniser for an HLS dataflow region of N_PROC concurrent processes, e.g. Block_proc and resize_nearest.
- Gates each process's ap_start so that no process starts iteration k+1 before every process has accepted iteration k.
- Exports per-process ready_count flags and one-cycle-delayed ap_idle. These are the signals consumed by the deadlock detector's proc_dep_vld logic.
- Adds a stall watchdog that flags when the processes stay partially ready for too long.

Parameters:
- N_PROC, 2, number of dataflow processes (>=2).
- STALL_W, 16, width of the stall cycle counter.
- STALL_LIMIT, 1000, partial-ready cycles before stall_flag asserts (must be < 2^STALL_W).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- ap_start  in  1  region start request.
- ap_ready  out  1  region accepted the current iteration; all processes ready or already counted.
- proc_ap_start  out  N_PROC  per-process start.
- proc_ap_ready  in  N_PROC  per-process ap_ready pulse/level.
- proc_ap_idle  in  N_PROC  per-process ap_idle.
- ready_count  out  N_PROC  per-process "already ready this iteration" flag.
- proc_idle_d  out  N_PROC  proc_ap_idle delayed one cycle.
- stall_flag  out  1  sticky watchdog flag.
- stall_origin  out  N_PROC  processes not yet ready when stall_flag set; captured at set time.
- stall_clear  in  1  clears stall_flag and stall_origin.

Behaviour:
- Reset: all registered outputs are 0 on any clock edge with reset==0. This covers ready_count, proc_idle_d, stall_flag, stall_origin and the stall counter. Reset mid-iteration discards partial ready state.
- Combinational outputs:
  - sync_vec[i] = proc_ap_ready[i] | ready_count[i].
  - ap_ready = &sync_vec. Zero latency, combinational.
  - proc_ap_start[i] = ap_start & ~ready_count[i].
- ready_count[i] next state, in priority order:
  - ap_ready==1 -> 0. This holds even if proc_ap_ready[i]==1 in the same cycle, since the iteration completes.
  - else proc_ap_ready[i]==1 -> 1.
  - else hold.
- ready_count is independent of ap_start; a process raising ap_ready without start still counts.
- Single-process completion in one cycle (all proc_ap_ready high together): ap_ready=1 that cycle, and all ready_count stay 0.
- proc_idle_d: registered copy of proc_ap_idle every cycle.
- Stall watchdog:
  - partial = (|ready_count) & ~ap_ready.
  - stall_cnt next state:
    - 0 if !partial.
    - else saturating increment, holding at STALL_LIMIT.
  - When partial and stall_cnt == STALL_LIMIT-1 and stall_flag==0: next cycle stall_flag=1, and stall_origin is set from the captured ~ready_count & ~proc_ap_ready.
  - stall_flag and stall_origin are sticky until stall_clear==1 or reset.
  - stall_clear wins over a same-cycle set; the counter is also zeroed by stall_clear.
  - After a clear while still partial, the count restarts from 0 and the flag can re-arm after another STALL_LIMIT cycles.
- Derived consumer fact: proc_dep_vld[i] = ready_count[i] & proc_ap_idle[i] & ~ready_count[j] (N_PROC=2). This is valid directly from these outputs, with no further glue.
- No X-propagation: unused bits beyond N_PROC do not exist; widths are exact.

Test Plan:
- Reset: hold reset=0 for 3 cycles with proc_ap_ready=2'b11 and ap_start=1 -> ready_count=0, stall_flag=0, proc_idle_d=0. Combinational ap_ready=1 and proc_ap_start=2'b11.
- Staggered ready, N_PROC=2, ap_start=1:
  - Cycle 0: proc_ap_ready=01 -> ap_ready=0. Cycle 1: ready_count=01, proc_ap_start=10.
  - Cycle 3: proc_ap_ready=10 -> ap_ready=1 that cycle. Cycle 4: ready_count=00, proc_ap_start=11.
- Simultaneous ready: proc_ap_ready=11 for one cycle -> ap_ready=1 same cycle; ready_count stays 00 throughout.
- Stall, STALL_LIMIT=8: proc 0 ready, proc 1 never ready -> stall_flag rises exactly 8 cycles after ready_count[0] rises, with stall_origin=10. Pulse stall_clear -> both 0 next cycle; flag re-asserts 8 cycles later.
- stall_clear in the same cycle as the set condition -> stall_flag stays 0 and the counter restarts.
- Reset mid-iteration: ready_count=01, then reset=0 for one cycle -> ready_count=00 and proc_ap_start=11 after release. proc_idle_d tracks a proc_ap_idle toggle pattern 1,0,1 with one-cycle lag.

Source files
------------

// File: rtl/dataflow_ready_sync.sv
// ---------------------------------------------------------------------------
// dataflow_ready_sync
//
// Start/ready synchroniser for an HLS dataflow region of N_PROC concurrent
// processes. It gates each process's ap_start so that no process can begin
// iteration k+1 until every process has accepted iteration k. It also exports
// the per-process "already ready" flags and a one-cycle-delayed ap_idle,
// which the deadlock detector consumes directly. A watchdog raises a sticky
// flag when the region stays partially ready for STALL_LIMIT cycles.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-low reset
//   ap_start       region start request
//   ap_ready       region accepted the current iteration (combinational)
//   proc_ap_start  per-process start, masked once that process has counted
//   proc_ap_ready  per-process ap_ready pulse/level
//   proc_ap_idle   per-process ap_idle
//   ready_count    per-process "already ready this iteration" flag
//   proc_idle_d    proc_ap_idle delayed by one cycle
//   stall_flag     sticky watchdog flag
//   stall_origin   processes still not ready when stall_flag was set
//   stall_clear    clears stall_flag, stall_origin and the stall counter
// ---------------------------------------------------------------------------
module dataflow_ready_sync #(
  parameter int N_PROC      = 2,
  parameter int STALL_W     = 16,
  parameter int STALL_LIMIT = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ap_start,
  output logic              ap_ready,
  output logic [N_PROC-1:0] proc_ap_start,
  input  logic [N_PROC-1:0] proc_ap_ready,
  input  logic [N_PROC-1:0] proc_ap_idle,
  output logic [N_PROC-1:0] ready_count,
  output logic [N_PROC-1:0] proc_idle_d,
  output logic              stall_flag,
  output logic [N_PROC-1:0] stall_origin,
  input  logic              stall_clear
);

  localparam logic [STALL_W-1:0] LIMIT    = STALL_W'(STALL_LIMIT);
  localparam logic [STALL_W-1:0] LIMIT_M1 = STALL_W'(STALL_LIMIT - 1);

  // Saturating increment: holds at LIMIT so the counter never wraps while
  // the region remains stuck.
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    if (v == LIMIT) begin
      sat_inc = v;
    end else begin
      sat_inc = v + STALL_W'(1);
    end
  endfunction

  logic [N_PROC-1:0]  sync_vec;
  logic               partial;
  logic               stall_set;
  logic [STALL_W-1:0] stall_cnt;

  // A process counts as synchronised either by its live ready or by having
  // already reported ready earlier in this iteration.
  assign sync_vec      = proc_ap_ready | ready_count;
  assign ap_ready      = &sync_vec;
  assign proc_ap_start = {N_PROC{ap_start}} & ~ready_count;

  // Partial: some process has counted but the iteration has not completed.
  assign partial   = (|ready_count) & ~ap_ready;
  assign stall_set = partial & (stall_cnt == LIMIT_M1) & ~stall_flag;

  // ---- registered stage: iteration state, idle delay, watchdog ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      ready_count  <= '0;
      proc_idle_d  <= '0;
      stall_cnt    <= '0;
      stall_flag   <= 1'b0;
      stall_origin <= '0;
    end else begin
      // Completion clears every flag, even for a process that is ready in
      // the completing cycle; otherwise ready is independent of ap_start.
      if (ap_ready) begin
        ready_count <= '0;
      end else begin
        ready_count <= ready_count | proc_ap_ready;
      end

      proc_idle_d <= proc_ap_idle;

      // Clear takes precedence over a same-cycle set and restarts the count.
      if (stall_clear) begin
        stall_cnt    <= '0;
        stall_flag   <= 1'b0;
        stall_origin <= '0;
      end else begin
        if (!partial) begin
          stall_cnt <= '0;
        end else begin
          stall_cnt <= sat_inc(stall_cnt);
        end
        if (stall_set) begin
          stall_flag   <= 1'b1;
          stall_origin <= ~ready_count & ~proc_ap_ready;
        end
      end
    end
  end

endmodule

// File: tb/tb_dataflow_ready_sync.sv
// Directed bench for dataflow_ready_sync with N_PROC=2, STALL_LIMIT=8.
module tb_dataflow_ready_sync;

  localparam int N_PROC      = 2;
  localparam int STALL_W     = 16;
  localparam int STALL_LIMIT = 8;

  logic              clock;
  logic              reset;
  logic              ap_start;
  logic              ap_ready;
  logic [N_PROC-1:0] proc_ap_start;
  logic [N_PROC-1:0] proc_ap_ready;
  logic [N_PROC-1:0] proc_ap_idle;
  logic [N_PROC-1:0] ready_count;
  logic [N_PROC-1:0] proc_idle_d;
  logic              stall_flag;
  logic [N_PROC-1:0] stall_origin;
  logic              stall_clear;

  int checks = 0;
  int errors = 0;

  dataflow_ready_sync #(
    .N_PROC(N_PROC),
    .STALL_W(STALL_W),
    .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ap_start(ap_start),
    .ap_ready(ap_ready),
    .proc_ap_start(proc_ap_start),
    .proc_ap_ready(proc_ap_ready),
    .proc_ap_idle(proc_ap_idle),
    .ready_count(ready_count),
    .proc_idle_d(proc_idle_d),
    .stall_flag(stall_flag),
    .stall_origin(stall_origin),
    .stall_clear(stall_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset         = 1'b0;
    ap_start      = 1'b1;
    proc_ap_ready = 2'b11;
    proc_ap_idle  = 2'b00;
    stall_clear   = 1'b0;

    // Reset held for three cycles
    repeat (3) step();
    check("rst_ready_count", ready_count, 2'b00);
    check("rst_stall_flag", stall_flag, 1'b0);
    check("rst_stall_origin", stall_origin, 2'b00);
    check("rst_idle_d", proc_idle_d, 2'b00);
    check("rst_ap_ready", ap_ready, 1'b1);
    check("rst_proc_start", proc_ap_start, 2'b11);

    reset = 1'b1;
    proc_ap_ready = 2'b00;
    #1;
    check("idle_ap_ready", ap_ready, 1'b0);

    // Staggered ready
    proc_ap_ready = 2'b01;
    #1;
    check("stag_c0_ap_ready", ap_ready, 1'b0);
    check("stag_c0_start", proc_ap_start, 2'b11);
    step();
    proc_ap_ready = 2'b00;
    #1;
    check("stag_c1_count", ready_count, 2'b01);
    check("stag_c1_start", proc_ap_start, 2'b10);
    check("stag_c1_ap_ready", ap_ready, 1'b0);
    ap_start = 1'b0;
    #1;
    check("stag_nostart", proc_ap_start, 2'b00);
    ap_start = 1'b1;
    step();
    check("stag_c2_count", ready_count, 2'b01);
    proc_ap_ready = 2'b10;
    #1;
    check("stag_c3_ap_ready", ap_ready, 1'b1);
    step();
    proc_ap_ready = 2'b00;
    #1;
    check("stag_c4_count", ready_count, 2'b00);
    check("stag_c4_start", proc_ap_start, 2'b11);

    // Simultaneous ready
    proc_ap_ready = 2'b11;
    #1;
    check("sim_ap_ready", ap_ready, 1'b1);
    check("sim_count_same", ready_count, 2'b00);
    step();
    proc_ap_ready = 2'b00;
    #1;
    check("sim_count_after", ready_count, 2'b00);
    check("sim_ap_ready_after", ap_ready, 1'b0);

    // Stall watchdog: process 0 ready, process 1 never
    proc_ap_ready = 2'b01;
    step();
    proc_ap_ready = 2'b00;
    check("stall_count", ready_count, 2'b01);
    for (int i = 1; i <= 7; i++) begin
      step();
      check($sformatf("stall_pre_%0d", i), stall_flag, 1'b0);
    end
    step();
    check("stall_set", stall_flag, 1'b1);
    check("stall_origin", stall_origin, 2'b10);
    check("stall_hold_start", proc_ap_start, 2'b10);
    step();
    check("stall_sticky", stall_flag, 1'b1);

    // Clear, then re-arm after another eight cycles
    stall_clear = 1'b1;
    step();
    stall_clear = 1'b0;
    check("clr_flag", stall_flag, 1'b0);
    check("clr_origin", stall_origin, 2'b00);
    for (int i = 1; i <= 7; i++) begin
      step();
      check($sformatf("rearm_pre_%0d", i), stall_flag, 1'b0);
    end
    step();
    check("rearm_set", stall_flag, 1'b1);
    check("rearm_origin", stall_origin, 2'b10);

    // Clear coinciding with the set condition
    stall_clear = 1'b1;
    step();
    stall_clear = 1'b0;
    check("clr2_flag", stall_flag, 1'b0);
    repeat (7) step();
    check("race_pre", stall_flag, 1'b0);
    stall_clear = 1'b1;
    step();
    stall_clear = 1'b0;
    check("race_flag", stall_flag, 1'b0);
    check("race_origin", stall_origin, 2'b00);
    for (int i = 1; i <= 7; i++) begin
      step();
      check($sformatf("race_restart_%0d", i), stall_flag, 1'b0);
    end
    step();
    check("race_restart_set", stall_flag, 1'b1);

    // Reset mid-iteration
    check("mid_count_before", ready_count, 2'b01);
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("mid_count", ready_count, 2'b00);
    check("mid_start", proc_ap_start, 2'b11);
    check("mid_flag", stall_flag, 1'b0);
    check("mid_origin", stall_origin, 2'b00);

    // Idle delay tracking
    proc_ap_idle = 2'b01;
    #1;
    check("idle_lag0", proc_idle_d, 2'b00);
    step();
    check("idle_d0", proc_idle_d, 2'b01);
    proc_ap_idle = 2'b10;
    #1;
    check("idle_lag1", proc_idle_d, 2'b01);
    step();
    check("idle_d1", proc_idle_d, 2'b10);
    proc_ap_idle = 2'b01;
    step();
    check("idle_d2", proc_idle_d, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
